// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Multi-cycle program-counter and fetch sequencer for the KGP miniRISC core.
//   It fetches one instruction over a ready handshake and holds it for
//   decode/execute. On execute completion it either stops the core (halt) or
//   loads the next PC: pc+4, a register target, or pc+sext(offset). It can
//   also emit a one-cycle return-address write (pc+4) for link instructions.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   imem_req/addr       fetch request (FETCH only), address = pc
//   imem_ready/rdata    memory handshake and instruction word
//   instr/instr_valid   latched instruction, valid while executing
//   exec_done           execute finished; branch/link/halt inputs are valid
//   branch_taken        branch decision
//   target_is_reg       1: reg_target, 0: pc + sext(offset)
//   offset, reg_target  branch target sources
//   link, halt          link and halt requests from the current instruction
//   pc                  address of the instruction being fetched/executed
//   link_we/link_addr   registered return-address write strobe and value
//   halted              core stopped; only rst leaves this state
module pc_sequencer #(
  parameter int                 ADDR_W   = 32,
  parameter int                 OFFSET_W = 26,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                branch_taken,
  input  logic                target_is_reg,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [ADDR_W-1:0]   reg_target,
  input  logic                link,
  input  logic                halt,
  output logic [ADDR_W-1:0]   pc,
  output logic                link_we,
  output logic [ADDR_W-1:0]   link_addr,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;

  // Next-PC datapath. All sums wrap modulo 2^ADDR_W by construction.
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] off_sext;
  logic [ADDR_W-1:0] pc_rel;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] next_pc;

  always_comb begin
    pc_plus4   = pc_q + ADDR_W'(4);
    off_sext   = ADDR_W'($signed(offset));
    pc_rel     = pc_q + off_sext;
    target_raw = pc_plus4;
    if (branch_taken) begin
      target_raw = target_is_reg ? reg_target : pc_rel;
    end
    // Every source is word-aligned, including a misaligned register target.
    next_pc = {target_raw[ADDR_W-1:2], 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    link_we_d   = 1'b0;          // strobe lasts a single cycle
    link_addr_d = link_addr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          // halt wins over branch and link: pc frozen, no link write.
          if (halt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
            if (link) begin
              link_we_d   = 1'b1;
              link_addr_d = pc_plus4;
            end
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
    end
  end

  // Status outputs decode straight from the registered state.
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign halted      = (state_q == S_HALT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign link_we     = link_we_q;
  assign link_addr   = link_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized instruction
// streams, checked against a plain-arithmetic model of the next-PC rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic        target_is_reg;
  logic [25:0] offset;
  logic [31:0] reg_target;
  logic        link;
  logic        halt;
  logic [31:0] pc;
  logic        link_we;
  logic [31:0] link_addr;
  logic        halted;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_pc;
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .OFFSET_W(26), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .target_is_reg(target_is_reg), .offset(offset), .reg_target(reg_target),
    .link(link), .halt(halt), .pc(pc),
    .link_we(link_we), .link_addr(link_addr), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference next-PC: integer arithmetic, then wrap to 32 bits and align.
  function automatic logic [31:0] model_next(input logic [31:0] old, input logic br,
                                             input logic isreg, input logic [25:0] off,
                                             input logic [31:0] regt);
    longint t;
    longint o;
    if (!br)        t = longint'(old) + 4;
    else if (isreg) t = longint'(regt);
    else begin
      o = longint'(off);
      if (o >= (longint'(1) << 25)) o = o - (longint'(1) << 26);
      t = longint'(old) + o;
    end
    return 32'(t) & 32'hFFFF_FFFC;
  endfunction

  // Called at a negedge while in FETCH; returns at the negedge in EXEC.
  task automatic do_fetch(input int waits);
    logic [31:0] d;
    d = $urandom;
    for (int w = 0; w < waits; w++) begin
      chk("fetch_req", imem_req, 1'b1);
      chk("fetch_addr_stable", imem_addr, exp_pc);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_no_valid", instr_valid, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = d;
    @(negedge clk);
    imem_ready = 1'b0;
    last_instr = d;
    chk("exec_valid", instr_valid, 1'b1);
    chk("exec_instr", instr, d);
    chk("exec_pc", pc, exp_pc);
    chk("link_we_one_cycle", link_we, 1'b0);
    chk("exec_no_req", imem_req, 1'b0);
  endtask

  // Called at a negedge in EXEC; returns at the negedge after exec_done.
  task automatic do_exec(input int waits, input logic br, input logic isreg,
                         input logic [25:0] off, input logic [31:0] regt,
                         input logic lnk, input logic hlt);
    logic [31:0] old;
    logic [31:0] nxt;
    old = exp_pc;
    for (int w = 0; w < waits; w++) begin
      chk("exec_hold_valid", instr_valid, 1'b1);
      chk("exec_hold_instr", instr, last_instr);
      exec_done     = 1'b0;
      branch_taken  = 1'($urandom);
      target_is_reg = 1'($urandom);
      link          = 1'($urandom);
      halt          = 1'($urandom);
      @(negedge clk);
    end
    exec_done = 1'b1; branch_taken = br; target_is_reg = isreg;
    offset = off; reg_target = regt; link = lnk; halt = hlt;
    nxt = model_next(old, br, isreg, off, regt);
    @(negedge clk);
    exec_done = 1'b0; halt = 1'b0; link = 1'b0;
    if (hlt) begin
      chk("halt_halted", halted, 1'b1);
      chk("halt_no_req", imem_req, 1'b0);
      chk("halt_pc", pc, old);
      chk("halt_no_link", link_we, 1'b0);
      chk("halt_no_valid", instr_valid, 1'b0);
    end else begin
      exp_pc = nxt;
      chk("next_req", imem_req, 1'b1);
      chk("next_pc", pc, nxt);
      chk("next_addr", imem_addr, nxt);
      chk("next_link_we", link_we, lnk);
      if (lnk) chk("next_link_addr", link_addr, old + 32'd4);
      chk("next_not_halted", halted, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    branch_taken = 1'b0; target_is_reg = 1'b0; offset = '0; reg_target = '0;
    link = 1'b0; halt = 1'b0; last_instr = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_link_we", link_we, 1'b0);
    chk("rst_link_addr", link_addr, 32'h0);
    chk("rst_halted", halted, 1'b0);
    rst = 1'b0;
    chk("idle_no_req", imem_req, 1'b0);
    @(negedge clk);
    exp_pc = 32'h0;

    // Sequential fetch 0, 4, 8, 0xC with random memory waits.
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      do_fetch($urandom_range(3, 0));
      do_exec(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    end

    // Random instruction stream.
    for (int i = 0; i < 40; i++) begin
      do_fetch($urandom_range(2, 0));
      do_exec($urandom_range(2, 0), 1'($urandom), 1'($urandom), 26'($urandom),
              $urandom, ($urandom_range(3, 0) == 0), 1'b0);
    end

    // Relative branch backwards, then fall-through.
    do_fetch(0); do_exec(0, 1'b1, 1'b1, '0, 32'h40, 1'b0, 1'b0);
    do_fetch(0); do_exec(0, 1'b1, 1'b0, 26'h3FF_FFF8, 32'hFFFF_0000, 1'b0, 1'b0);
    chk("rel_branch_target", pc, 32'h38);
    do_fetch(0); do_exec(0, 1'b1, 1'b1, '0, 32'h40, 1'b0, 1'b0);
    do_fetch(1); do_exec(0, 1'b0, 1'b0, 26'h3FF_FFF8, '0, 1'b0, 1'b0);
    chk("not_taken_target", pc, 32'h44);

    // Register branch with link, misaligned target.
    do_fetch(0); do_exec(0, 1'b1, 1'b1, '0, 32'h100, 1'b0, 1'b0);
    do_fetch(0); do_exec(0, 1'b1, 1'b1, '0, 32'h2003, 1'b1, 1'b0);
    chk("reg_link_pc", pc, 32'h2000);
    chk("reg_link_addr", link_addr, 32'h104);

    // Wrap-around.
    do_fetch(0); do_exec(0, 1'b1, 1'b1, '0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    do_fetch(2); do_exec(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("wrap_pc", pc, 32'h0);

    // Halt beats branch and link; stays halted with noisy inputs.
    do_fetch(0); do_exec(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_fetch(1); do_exec(1, 1'b1, 1'b1, '0, 32'h3000, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom); exec_done = 1'($urandom);
      @(negedge clk);
      chk("halt_hold_req", imem_req, 1'b0);
      chk("halt_hold_halted", halted, 1'b1);
      chk("halt_hold_pc", pc, 32'h4);
      chk("halt_hold_link_we", link_we, 1'b0);
    end
    imem_ready = 1'b0; exec_done = 1'b0;

    // Reset out of HALT, then reset mid-FETCH with imem_ready high.
    rst = 1'b1;
    #1;
    chk("rst2_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    @(negedge clk);
    do_fetch(0); do_exec(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    do_fetch(1); do_exec(0, 1'b1, 1'b1, '0, 32'h500, 1'b0, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    chk("rst_mid_pc", pc, 32'h0);
    chk("rst_mid_instr", instr, 32'h0);
    chk("rst_mid_valid", instr_valid, 1'b0);
    chk("rst_mid_req", imem_req, 1'b0);
    @(negedge clk);
    chk("rst_mid_instr_edge", instr, 32'h0);
    rst = 1'b0;
    chk("rst_rel_no_req", imem_req, 1'b0);
    @(negedge clk);
    imem_ready = 1'b0;
    chk("rst_rel_instr", instr, 32'h0);
    chk("rst_rel_valid", instr_valid, 1'b0);
    exp_pc = 32'h0;
    do_fetch(1); do_exec(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_rel_seq", pc, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter and fetch sequencer for the KGP miniRISC core. It holds the PC and fetches each instruction from instruction memory over a ready handshake. It presents the instruction to decode/execute and waits for execute completion. It then updates the PC using the branch-taken decision from the branch control block, the sign-extended offset or register target, and link/halt requests.

## Interface
- ADDR_W, 32, PC and address width.
- OFFSET_W, 26, width of the signed PC-relative byte offset.
- RESET_PC, 0, PC value loaded on reset. Low 2 bits must be 0.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, high only in FETCH.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_ready  in  1  instruction memory has imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction; stable for the whole EXEC state.
- instr_valid  out  1  high exactly while in EXEC.
- exec_done  in  1  execute finished; branch/link/halt inputs are valid this cycle.
- branch_taken  in  1  branch decision from the branch control block.
- target_is_reg  in  1  1: target = reg_target; 0: target = pc + sext(offset).
- offset  in  OFFSET_W  signed byte offset, relative to the current instruction's pc.
- reg_target  in  ADDR_W  register-sourced branch target.
- link  in  1  store the return address (pc+4).
- halt  in  1  the current instruction is halt.
- pc  out  ADDR_W  address of the instruction being fetched or executed.
- link_we  out  1  one-cycle return-address write strobe.
- link_addr  out  ADDR_W  return address; valid while link_we is high.
- halted  out  1  core is stopped.

## Operation
- States: IDLE, FETCH, EXEC, HALT. State is registered; imem_req, instr_valid and halted decode from the state.
- Reset: state=IDLE, pc=RESET_PC, instr=0, link_we=0, link_addr=0. All outputs are therefore 0, except pc and imem_addr, which equal RESET_PC.
- IDLE: unconditionally goes to FETCH on the next edge.
- FETCH: imem_req=1 and imem_addr=pc, held until imem_ready. On imem_ready: instr<=imem_rdata, go to EXEC. imem_ready is ignored in all other states.
- EXEC: instr_valid=1. The block waits for exec_done, which is ignored in all other states. On exec_done, in priority order:
  - halt=1: pc unchanged, go to HALT. Branch and link are ignored.
  - Otherwise: pc<=next_pc and go to FETCH, where next_pc is:
    - branch_taken=0: pc+4.
    - branch_taken=1 and target_is_reg=1: reg_target.
    - branch_taken=1 and target_is_reg=0: pc+sext(offset).
  - link=1, with or without branch_taken: link_we=1 for exactly the following cycle, and link_addr=old pc+4.
- Arithmetic: all additions are modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0, with no error.
- Alignment: next_pc[1:0] is forced to 2'b00 for every source.
- HALT: halted=1, imem_req=0, pc frozen. The block leaves HALT only through rst.

## Timing
- Best case is 2 cycles per instruction: FETCH with imem_ready in the same cycle, then EXEC with exec_done in the same cycle.
- The first imem_req is asserted in the 2nd cycle after rst deasserts.
- pc and instr change only on the edge that leaves EXEC or FETCH respectively. imem_addr is stable throughout a request.
- link_we and link_addr are registered and appear in the cycle after exec_done, which is the first cycle of the next FETCH.
- halted rises in the cycle after exec_done with halt.
- rst asserted mid-FETCH or mid-EXEC clears everything immediately (asynchronous). The pending fetch is abandoned, and a late imem_ready during or after reset has no effect.

## Test plan
- Sequential fetch: RESET_PC=0, imem_ready with 0-3 random wait cycles, exec_done after 1 cycle, no branch. Required: imem_addr sequence 0, 4, 8, 0xC; instr matches imem_rdata.
- Taken relative branch: at pc=0x40, branch_taken=1, offset=-8. Required: next fetch at 0x38. With branch_taken=0, the next fetch is 0x44.
- Register branch with link: at pc=0x100, branch_taken=1, target_is_reg=1, reg_target=0x2003, link=1. Required: next fetch at 0x2000; link_we pulses once with link_addr=0x104.
- Wrap-around: at pc=0xFFFFFFFC, no branch. Required: next fetch at 0x00000000.
- Halt priority: halt=1 together with branch_taken=1 and link=1. Required: halted=1, pc unchanged, link_we=0, imem_req stays 0 for 20 cycles.
- Reset mid-operation: assert rst during FETCH while imem_ready is high in the same cycle. Required: pc=RESET_PC, instr=0, instr_valid=0; fetch restarts at RESET_PC 2 cycles after release.
